inv_sub_bytes_iter: RTL and testbench

- Iterative AES InvSubBytes stage that sits directly downstream of Inverse_Shift_Row in the decryption round datapath.
- Takes the 128-bit state emitted by InvShiftRows and applies the FIPS-197 inverse S-box to every byte.
- Processes BYTES_PER_CYCLE bytes per clock, so only a few inverse S-box instances are needed instead of 16.
- Uses valid/ready handshakes on both sides so it slots between combinational round stages and the round-key adder.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/inv_sbox.sv | 14 +
 rtl/inv_sub_bytes_iter.sv | 117 +++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES tables, widths and the iterative-stage FSM encoding.
package aes_pkg;

    localparam int unsigned STATE_W = 128;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = $clog2(STATE_W);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } iter_state_e;

    // FIPS-197 inverse S-box, indexed by the substituted byte value.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte 0 sits in the top bits of the state; return the MSB position of byte idx.
    function automatic logic [IDX_W-1:0] byte_msb(input int unsigned idx);
        return IDX_W'(STATE_W - 1 - idx * BYTE_W);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Single-byte combinational inverse S-box lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    output logic [BYTE_W-1:0] byte_o
);

    // Table lookup into the shared inverse S-box.
    always_comb begin
        byte_o = INV_SBOX[byte_i];
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE bytes of the captured state per cycle,
// with valid/ready handshakes on input and output.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] Data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] Data_OUT,
    output logic               busy
);

    localparam int unsigned NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bytes_per_cycle
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    iter_state_e        state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [STATE_W-1:0] data_q, data_d;

    logic [BYTE_W-1:0]  sb_in  [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0]  sb_out [BYTES_PER_CYCLE];

    // Select the chunk of bytes addressed by the current step.
    always_comb begin
        for (int unsigned k = 0; k < BYTES_PER_CYCLE; k++) begin
            sb_in[k] = data_q[byte_msb(32'(step_q) * BYTES_PER_CYCLE + k) -: BYTE_W];
        end
    end

    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .byte_i (sb_in[k]),
            .byte_o (sb_out[k])
        );
    end

    // Next-state, datapath write-back and handshake outputs.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        Data_OUT  = '0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = Data;
                    step_d  = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                busy = 1'b1;
                for (int unsigned k = 0; k < BYTES_PER_CYCLE; k++) begin
                    data_d[byte_msb(32'(step_q) * BYTES_PER_CYCLE + k) -: BYTE_W] = sb_out[k];
                end
                if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                    step_d  = '0;
                    state_d = StDone;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                Data_OUT  = data_q;
                // Output hand-off frees the register, so a new block may be taken in the same cycle.
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        data_d  = Data;
                        step_d  = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter: default DUT plus 1/2/16 bytes-per-cycle variants.
module tb_inv_sub_bytes_iter;

    localparam int unsigned NSTEPS = 4;
    localparam logic [127:0] FIPS_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] FIPS_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    logic         sw_valid;
    logic         sw_ready;
    logic [127:0] sw_data;
    logic [2:0]   sw_in_ready;
    logic [2:0]   sw_out_valid;
    logic [2:0]   sw_busy;
    logic [127:0] sw_out [3];

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_tab [256];

    inv_sub_bytes_iter u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data      (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Data_OUT  (data_out),
        .busy      (busy)
    );

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_dut_b1 (
        .clk (clk), .rst (rst), .in_valid (sw_valid), .in_ready (sw_in_ready[0]),
        .Data (sw_data), .out_valid (sw_out_valid[0]), .out_ready (sw_ready),
        .Data_OUT (sw_out[0]), .busy (sw_busy[0])
    );

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(2)) u_dut_b2 (
        .clk (clk), .rst (rst), .in_valid (sw_valid), .in_ready (sw_in_ready[1]),
        .Data (sw_data), .out_valid (sw_out_valid[1]), .out_ready (sw_ready),
        .Data_OUT (sw_out[1]), .busy (sw_busy[1])
    );

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_dut_b16 (
        .clk (clk), .rst (rst), .in_valid (sw_valid), .in_ready (sw_in_ready[2]),
        .Data (sw_data), .out_valid (sw_out_valid[2]), .out_ready (sw_ready),
        .Data_OUT (sw_out[2]), .busy (sw_busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: inverse affine transform, then multiplicative inverse in GF(2^8).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox_model(input logic [7:0] b);
        logic [7:0] y;
        y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        if (y == 8'h00) return 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(8'(x), y) == 8'h01) return 8'(x);
        end
        return 8'h00;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = ref_tab[d[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer d until accepted (bounded); afterwards scramble Data to prove it is not re-sampled.
    task automatic accept(input logic [127:0] d, output bit ok);
        int n = 0;
        in_valid = 1'b1;
        data_in  = d;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        ok = (n < 50);
        tick();
        in_valid = 1'b0;
        data_in  = rand128();
    endtask

    // Count cycles until out_valid; tally RUN-phase anomalies (Data_OUT leak, in_ready, busy).
    task automatic wait_out(output int lat, output int bad);
        lat = 0;
        bad = 0;
        while (!out_valid && lat < 60) begin
            if (data_out !== 128'h0 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    endtask

    task automatic test_vector(input string name, input logic [127:0] d, input logic [127:0] exp);
        bit ok;
        int lat, bad;
        accept(d, ok);
        wait_out(lat, bad);
        checks++; if (!ok) begin errors++; $display("FAIL %s_accept: in_ready never rose", name); end
        checks++; if (lat != NSTEPS) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, NSTEPS); end
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_run_outputs: %0d bad cycles want 0", name, bad); end
        checks++; if (data_out !== exp) begin errors++; $display("FAIL %s_data: got %h want %h", name, data_out, exp); end
        consume();
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            logic [127:0] d, exp;
            bit ok;
            int lat, bad, hold, moved;
            d   = rand128();
            exp = model(d);
            accept(d, ok);
            wait_out(lat, bad);
            checks++; if (!ok || lat != NSTEPS || bad != 0) begin errors++;
                $display("FAIL rand%0d_timing: ok=%0b lat=%0d bad=%0d want lat %0d", b, ok, lat, bad, NSTEPS); end
            checks++; if (data_out !== exp) begin errors++; $display("FAIL rand%0d_data: got %h want %h", b, data_out, exp); end
            hold  = $urandom_range(0, 3);
            moved = 0;
            for (int c = 0; c < hold; c++) begin
                tick();
                if (out_valid !== 1'b1 || data_out !== exp) moved++;
            end
            checks++; if (moved != 0) begin errors++; $display("FAIL rand%0d_hold: %0d unstable cycles want 0", b, moved); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b;
        bit ok;
        int lat, bad, moved;
        a = rand128();
        b = rand128();
        accept(a, ok);
        wait_out(lat, bad);
        moved = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            data_in   = b;
            out_ready = 1'b0;
            #1;
            if (out_valid !== 1'b1 || data_out !== model(a) || in_ready !== 1'b0) moved++;
            tick();
        end
        checks++; if (moved != 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles want 0", moved); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_overlap_ready: got %b want 1", in_ready); end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = rand128();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL bp_recapture: out_valid=%b busy=%b want 0/1", out_valid, busy); end
        wait_out(lat, bad);
        checks++; if (lat != NSTEPS) begin errors++; $display("FAIL bp_second_latency: got %0d want %0d", lat, NSTEPS); end
        checks++; if (data_out !== model(b)) begin errors++; $display("FAIL bp_second_data: got %h want %h", data_out, model(b)); end
        consume();
    endtask

    // Continuous streaming: each new block is taken in the DONE cycle of the previous one,
    // so results are NSTEPS+1 cycles apart (hand-off cycle plus NSTEPS latency).
    task automatic test_back_to_back();
        logic [127:0] blocks [4];
        logic [127:0] exp_q [$];
        int sent = 0, got = 0, last_t = -1;
        for (int i = 0; i < 4; i++) blocks[i] = rand128();
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            in_valid  = (sent < 4);
            data_in   = (sent < 4) ? blocks[sent] : 128'h0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                logic [127:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                checks++; if (data_out !== e) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", got, data_out, e); end
                if (last_t >= 0) begin
                    checks++; if (cyc - last_t != NSTEPS + 1) begin errors++;
                        $display("FAIL b2b_spacing%0d: got %0d want %0d", got, cyc - last_t, NSTEPS + 1); end
                end
                last_t = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(blocks[sent]));
                sent++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int stale = 0;
        accept(rand128(), ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || data_out !== 128'h0) begin
            errors++;
            $display("FAIL rst_run_state: ov=%b ir=%b busy=%b dout=%h want 0/1/0/0", out_valid, in_ready, busy, data_out);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid !== 1'b0) stale++;
        end
        out_ready = 1'b0;
        checks++; if (stale != 0) begin errors++; $display("FAIL rst_run_stale: got %0d valid cycles want 0", stale); end
    endtask

    task automatic test_sweep();
        int want_lat [3] = '{16, 8, 1};
        int lat [3] = '{0, 0, 0};
        logic [127:0] seen [3];
        sw_data  = FIPS_IN;
        sw_valid = 1'b1;
        #1;
        checks++; if (sw_in_ready !== 3'b111) begin errors++; $display("FAIL sweep_ready: got %b want 111", sw_in_ready); end
        tick();
        sw_valid = 1'b0;
        sw_data  = rand128();
        for (int cyc = 1; cyc <= 24; cyc++) begin
            tick();
            for (int j = 0; j < 3; j++) begin
                if (sw_out_valid[j] && lat[j] == 0) begin
                    lat[j]  = cyc;
                    seen[j] = sw_out[j];
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            checks++; if (lat[j] != want_lat[j]) begin errors++;
                $display("FAIL sweep%0d_latency: got %0d want %0d", j, lat[j], want_lat[j]); end
            checks++; if (seen[j] !== FIPS_OUT) begin errors++;
                $display("FAIL sweep%0d_data: got %h want %h", j, seen[j], FIPS_OUT); end
        end
        sw_ready = 1'b1;
        tick();
        sw_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        sw_valid  = 1'b0;
        sw_ready  = 1'b0;
        sw_data   = '0;
        for (int i = 0; i < 256; i++) ref_tab[i] = inv_sbox_model(8'(i));
        #1;

        test_reset();
        test_vector("zero", 128'h0, {16{8'h52}});
        test_vector("fips_round1", FIPS_IN, FIPS_OUT);
        test_vector("byte_order", {4{32'h637cff01}}, {4{32'h00017d09}});
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
